// File: rtl/alu_iterative.sv
// Execute-stage ALU: single-cycle logic/arith/shift/compare ops plus iterative
// shift-add multiply and restoring unsigned divide/remainder behind valid/ready.
module alu_iterative #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  localparam int unsigned CW = SHW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;   // multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplier (MUL) or dividend/quotient (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;   // product accumulator or partial remainder
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rem_sel_q, rem_sel_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             out_valid_q, out_valid_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             slt_bit;
  logic             sltu_bit;

  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  assign shamt    = b[SHW-1:0];
  assign slt_bit  = $signed(a) < $signed(b);
  assign sltu_bit = a < b;

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = a + b;
      4'd1:    alu_res = a - b;
      4'd2:    alu_res = a & b;
      4'd3:    alu_res = a | b;
      4'd4:    alu_res = a ^ b;
      4'd5:    alu_res = a << shamt;
      4'd6:    alu_res = a >> shamt;
      4'd7:    alu_res = $signed(a) >>> shamt;
      4'd8:    alu_res = {{(WIDTH-1){1'b0}}, slt_bit};
      4'd9:    alu_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      default: alu_res = '0;
    endcase
  end

  // Remainder is always below the divisor, so only the top trial bit is needed
  // to decide; the subtraction itself fits in WIDTH bits.
  assign mul_acc_next = acc_q + (opb_q[0] ? opa_q : '0);
  assign div_trial    = {acc_q, opb_q[WIDTH-1]};
  assign div_ge       = div_trial >= {1'b0, opa_q};
  assign div_rem_next = div_ge ? (div_trial[WIDTH-1:0] - opa_q) : div_trial[WIDTH-1:0];
  assign div_quo_next = {opb_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d     = state_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    rem_sel_d   = rem_sel_q;
    result_d    = result_q;
    out_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (op == 4'd10) begin
            opa_d   = a;
            opb_d   = b;
            acc_d   = '0;
            cnt_d   = CW'(WIDTH);
            state_d = ST_MUL;
          end else if (op == 4'd11 || op == 4'd12) begin
            opa_d     = b;
            opb_d     = a;
            acc_d     = '0;
            cnt_d     = CW'(WIDTH);
            rem_sel_d = (op == 4'd12);
            state_d   = ST_DIV;
          end else begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = mul_acc_next;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d    = mul_acc_next;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_DIV: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d = div_rem_next;
          opb_d = div_quo_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            result_d    = rem_sel_q ? div_rem_next : div_quo_next;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      rem_sel_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      rem_sel_q   <= rem_sel_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Parametrised execute-stage ALU, successor to the single-cycle 64-bit ALU. Adds XOR, shifts, set-less-than, and iterative multiply/divide/remainder behind a valid/ready handshake. Results are registered. The block raises `busy` so the hazard unit can stall the front of the pipeline during multi-cycle operations. Forwarding stays external: operands arrive already muxed.

## Interface
- `WIDTH`, default 64: operand and result width. Must be a power of two, ≥ 8.
- `SHW`, default $clog2(WIDTH): shift-amount width. Derived, not overridden.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: block can accept a request this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `op` in 4: operation code.
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU
  - 10 MUL (low WIDTH bits), 11 DIVU, 12 REMU
  - 13–15 reserved, result 0
- `flush` in 1: synchronous abort.
- `out_valid` out 1: one-cycle pulse; `result` and `zero` are valid.
- `result` out WIDTH: registered result.
- `zero` out 1: `result == 0`, decoded from the result register.
- `busy` out 1: multi-cycle operation in progress; equals `!in_ready`.

## Operation
- A request is accepted on a rising edge when `in_valid && in_ready`. No output backpressure; the consumer must take `out_valid`.
- State machine:
  - **IDLE**: `in_ready = 1`.
    - Ops 0–9 and 13–15: compute combinationally, register `result`, set `out_valid`, stay IDLE.
    - Op 10: load multiplicand, multiplier, zeroed accumulator and counter = WIDTH; go to MUL.
    - Ops 11–12: load dividend, divisor, zeroed remainder and counter = WIDTH; go to DIV.
  - **MUL**: shift-add, one multiplier bit per cycle, LSB first. When the counter reaches 0, write the low WIDTH bits to `result`, pulse `out_valid`, go to IDLE.
  - **DIV**: restoring division, unsigned, one quotient bit per cycle, MSB first. On completion, write the quotient (DIVU) or remainder (REMU), pulse `out_valid`, go to IDLE.
- Width and arithmetic rules:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Shift amount is `b[SHW-1:0]`; upper bits of `b` are ignored.
  - SRA sign-fills.
  - SLT is signed, SLTU is unsigned; both produce 0 or 1 zero-extended.
- Divide by zero (`b == 0`): DIVU returns all ones, REMU returns `a`. The full WIDTH cycles still elapse; latency is data-independent.
- `flush`:
  - In MUL or DIV: abort to IDLE at the next edge, with no `out_valid`.
  - In IDLE: suppresses acceptance that cycle and forces `out_valid` low next cycle.
  - `result` is unchanged by a flush.
- `in_valid` while busy is ignored; the requester must hold the request until `in_ready`.

## Timing
- Reset values: state IDLE, `in_ready` 1, `busy` 0, `out_valid` 0, `result` 0, `zero` 1, counter 0.
- Single-cycle ops: accepted at edge T; `out_valid` and `result` are valid in the cycle after T. Back-to-back issue every cycle is supported.
- Multi-cycle ops:
  - Accepted at edge T; iterations occur at edges T+1 through T+WIDTH.
  - `out_valid` is high in the cycle after T+WIDTH (latency WIDTH+1 cycles).
  - `in_ready` is low from after T through edge T+WIDTH. It is high again in the same cycle as `out_valid`, so a new request can be accepted in that cycle.
- `out_valid` is never high for more than one cycle per accepted request.
- `flush` takes priority over completion. A flush in the final iteration cycle suppresses `out_valid`.
- Reset asserted mid-operation returns immediately to the reset values; no pulse occurs on deassertion.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `in_ready` 1, `out_valid` 0, `result` 0, `zero` 1. Check that all outputs hold these values until the first accepted request.
- **ADD wrap:** ADD of all ones plus 1 → `result` 0 and `zero` 1 one cycle later. Then SUB 5−7 → `result` 0xFFFF_FFFF_FFFF_FFFE. Then SLT −2<1 → 1, and SLTU on the same operands → 0.
- **Shift masking:** SRA of 0x8000_0000_0000_0000 with `b` = 68 (uses 4) → 0xF800_0000_0000_0000. SLL of 1 with `b` = 63 → 0x8000_0000_0000_0000.
- **MUL:** 0x1_0000_0001 × 3 → 0x3_0000_0003, with `out_valid` exactly 65 cycles after acceptance. Hold `in_valid` high with ADD throughout; check it is accepted only in the `out_valid` cycle.
- **Divide:** DIVU 100/7 → 14. REMU 100/7 → 2. DIVU x/0 → 0xFFFF_FFFF_FFFF_FFFF. REMU 9/0 → 9. Latency is 65 cycles for each.
- **Flush and parametrisation:**
  - Flush at iteration 30 of a MUL → no `out_valid`, `in_ready` high next cycle, previous `result` retained.
  - Rerun all of the above with `WIDTH` = 32, expecting 33-cycle latency.
